fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined RV32I core.
- Owns the PC register and drives the address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles hazard-unit stall/flush and EX-stage branch/jump redirects; keeps a sticky misalignment flag and a fetched-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
stall_f  input  1  hold PC (hazard unit)
stall_d  input  1  hold IF/ID register (hazard unit)
flush_d  input  1  squash IF/ID contents (hazard unit)
pc_src_e  input  1  taken branch/jump resolved in EX
pc_target_e  input  32  redirect target from EX
imem_addr  output  32  address to instruction memory (= pc_f)
imem_instr  input  32  instruction returned combinationally
pc_f  output  32  current fetch PC
instr_d  output  32  IF/ID instruction
pc_d  output  32  IF/ID PC
pc_plus4_d  output  32  IF/ID PC+4
valid_d  output  1  IF/ID holds a real fetched instruction
fetch_misaligned  output  1  sticky: a redirect target had [1:0]!=0
fetch_count  output  32  instructions loaded into IF/ID since reset

Behaviour:
- Reset (rst_n=0, asynchronous, any cycle incl. mid-stall/redirect): pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, fetch_misaligned=0, fetch_count=0. First fetch from RESET_PC in the first cycle after release.
- imem_addr = pc_f, combinational, no extra latency; instruction available the same cycle.
- PC update priority per edge: (1) pc_src_e=1: pc_f <= {pc_target_e[31:2],2'b00}; redirect overrides stall_f. (2) stall_f=1: hold. (3) else pc_f <= pc_f+4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000, no flag).
- Misalignment: pc_src_e=1 with pc_target_e[1:0]!=0 sets fetch_misaligned=1 at that edge; only reset clears it.
- IF/ID priority per edge: (1) flush_d=1: instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0; flush beats stall_d. (2) stall_d=1: all IF/ID outputs hold. (3) else instr_d=imem_instr, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1.
- A zero word from unmapped memory is passed through unchanged with valid_d=1; decode flags it as illegal.
- fetch_count increments by 1, wrapping, only on edges taking IF/ID case (3); unchanged on flush or stall.
- Stage does not itself flush on pc_src_e; the hazard unit asserts flush_d (and flush_e) alongside it.
- Simultaneous pc_src_e=1, stall_f=1, flush_d=1: PC takes the target, IF/ID becomes a bubble, count unchanged.
- Single clock domain; no combinational path from any input to pc_f or the IF/ID outputs except imem_addr=pc_f.

Test Plan:
- Reset then 6 free-running cycles: pc_f steps 0x0,0x4,...,0x14; after 1st edge instr_d=0xFFC4A303 (lw x6,-4(x9)), pc_d=0x0, pc_plus4_d=0x4, valid_d=1; fetch_count=6 after 6 edges.
- stall_f=stall_d=1 for 3 cycles at pc_f=0x8: pc_f stays 0x8, instr_d/pc_d=0x4 held, fetch_count frozen; release resumes at 0xC.
- At pc_f=0x1C assert pc_src_e=1, pc_target_e=0x0, flush_d=1 (beq x4,x4,L7): next pc_f=0x0, instr_d=0x00000013, valid_d=0; following edge instr_d=0xFFC4A303, pc_d=0x0.
- pc_src_e=1, stall_f=1, pc_target_e=0x40 together: pc_f=0x40 (redirect beats stall).
- pc_target_e=0x42 with pc_src_e=1: pc_f=0x40, fetch_misaligned=1, and stays 1 across further redirects until rst_n low.
- Force pc_f to 0xFFFF_FFFC via redirect, run one free cycle: pc_f=0x0, pc_plus4_d=0x0; assert rst_n=0 mid-cycle: all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, instruction-memory address and IF/ID register.
// Also tracks a sticky redirect-misalignment flag and a count of instructions handed to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fetch_misaligned,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4_f;

  assign pc_plus4_f = pc_f_q + 32'd4;

  // IF: next PC; a redirect from EX wins over a fetch stall
  always_comb begin
    pc_f_d       = pc_f_q;
    misaligned_d = misaligned_q;
    if (pc_src_e) begin
      pc_f_d = {pc_target_e[31:2], 2'b00};
      if (pc_target_e[1:0] != 2'b00) misaligned_d = 1'b1;
    end else if (!stall_f) begin
      pc_f_d = pc_plus4_f;
    end
  end

  // IF/ID: flush beats stall; only a real load bumps the fetch counter
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_vld_d   = ifid_vld_q;
    count_d      = count_q;
    if (flush_d) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = 32'd0;
      ifid_pc4_d   = 32'd0;
      ifid_vld_d   = 1'b0;
    end else if (!stall_d) begin
      ifid_instr_d = imem_instr;
      ifid_pc_d    = pc_f_q;
      ifid_pc4_d   = pc_plus4_f;
      ifid_vld_d   = 1'b1;
      count_d      = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q       <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_vld_q   <= 1'b0;
      misaligned_q <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      pc_f_q       <= pc_f_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_vld_q   <= ifid_vld_d;
      misaligned_q <= misaligned_d;
      count_q      <= count_d;
    end
  end

  assign imem_addr        = pc_f_q;
  assign pc_f             = pc_f_q;
  assign instr_d          = ifid_instr_q;
  assign pc_d             = ifid_pc_q;
  assign pc_plus4_d       = ifid_pc4_q;
  assign valid_d          = ifid_vld_q;
  assign fetch_misaligned = misaligned_q;
  assign fetch_count      = count_q;

endmodule
